automata_report_collector: RTL and testbench
============================================

Name: automata_report_collector

Overview:
- Sits directly downstream of the per-cluster automata stage.
- Consumes the stage's one-bit report wires (52 per cluster) and serialises every asserted report into an {id, timestamp} record.
- Buffers records in a FIFO and hands them to the monitor readout logic over a valid/ready interface.
- Automata stages cannot be back-pressured, so overload is handled by counted, flagged drops.

Parameters:
- NUM_REPORTS, 52, number of report inputs; bit i carries report id i.
- ID_WIDTH, 6, width of report id; must satisfy 2^ID_WIDTH >= NUM_REPORTS.
- TS_WIDTH, 32, width of the symbol-cycle timestamp.
- FIFO_DEPTH, 16, record FIFO entries; power of two, >= 2.
- DROP_WIDTH, 16, width of the drop counter.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- run  in  1  symbol-cycle qualifier; same meaning as the automata stages' run.
- report_vec  in  NUM_REPORTS  report wires from the stage; sampled only when run=1.
- out_valid  out  1  FIFO head record valid.
- out_ready  in  1  consumer accepts head record.
- out_id  out  ID_WIDTH  report id of head record.
- out_ts  out  TS_WIDTH  timestamp of head record.
- fifo_level  out  clog2(FIFO_DEPTH+1)  current FIFO occupancy.
- busy  out  1  collector in DRAIN state.
- overflow  out  1  sticky; set on any dropped vector.
- drop_count  out  DROP_WIDTH  number of dropped report vectors; saturating.

Behaviour:
Reset (reset=0 at a clock edge):
- State goes to IDLE; pending vector, ts_count, ts_latched, FIFO pointers and count all clear to 0.
- overflow and drop_count clear to 0. All outputs read 0, including out_id and out_ts.
- Reset mid-drain discards pending bits and all FIFO contents with no partial output.

Timestamp:
- ts_count increments by 1 on every edge with run=1; it wraps silently at 2^TS_WIDTH.
- A sampled vector is stamped with the ts_count value of its sampling cycle, i.e. the pre-increment value.

State machine (states IDLE, DRAIN):
- IDLE: if run=1 and report_vec!=0, load pending<=report_vec and ts_latched<=ts_count, then go to DRAIN. Otherwise stay in IDLE.
- DRAIN: each cycle, pick the lowest set bit k of pending.
  - If FIFO count < FIFO_DEPTH, push {k, ts_latched} and clear bit k. Otherwise stall with pending unchanged.
  - When the cycle clears the last set bit:
    - if run=1 and report_vec!=0 in that same cycle, load the new vector and its timestamp and stay in DRAIN (back-to-back, no drop);
    - else go to IDLE.
  - Any other DRAIN cycle with run=1 and report_vec!=0 (including stalled cycles): the vector is dropped, overflow<=1, and drop_count increments, saturating at all-ones.
- run=0 cycles never sample, never drop and never advance ts_count. Draining continues regardless of run.
- busy=1 exactly when state is DRAIN.

FIFO:
- Push is allowed only when count < FIFO_DEPTH as evaluated at the start of the cycle. There is no push-through when full, even if a pop occurs in the same cycle.
- Pop occurs when out_valid=1 and out_ready=1. A simultaneous push and pop leaves count unchanged.
- out_valid = (count != 0). out_id and out_ts show the head entry. There is no bypass.
- Pointers wrap modulo FIFO_DEPTH.
- out_id, out_ts and out_valid must hold stable while out_valid=1 and out_ready=0.

Latency:
- Report sampled in cycle T → pending loaded at edge T+1 → pushed in cycle T+1 → out_valid=1 in cycle T+2 (empty FIFO, first bit).
- Each further set bit in the same vector adds 1 cycle.

Test Plan:
- Single report: after reset, run=1 with report_vec bit 5 set at ts_count=0. Expect out_valid=1 exactly 2 cycles later with out_id=5, out_ts=0; out_ready=1 pops it; fifo_level returns to 0.
- Ordering: vector with bits {40,3,17} set at ts_count=7. Expect records 3,17,40 on consecutive cycles, all with out_ts=7; busy high for 3 cycles.
- Back-pressure/drop: out_ready=0, vector with 20 bits set. FIFO fills to 16 and the collector stalls in DRAIN. A second nonzero vector while stalled sets overflow=1 and drop_count=1. After raising out_ready, all 20 records drain in id order.
- Back-to-back: a two-bit vector, then a new nonzero vector on exactly the cycle the last bit clears. Expect no drop (drop_count=0) and the second vector's records carrying their own timestamp.
- Timestamp gaps: run toggles 1,0,0,1 with a report on the 4th cycle. Expect out_ts=1; run=0 cycles carrying nonzero report_vec produce no records.
- Reset mid-operation: reset=0 while draining with FIFO at 5 entries. Next cycle fifo_level=0, out_valid=0, busy=0, overflow=0, drop_count=0, and the next sampled report gets out_ts=0.

Source files
------------

// File: rtl/automata_report_collector.sv
`default_nettype none
// ============================================================================
//  Module      : automata_report_collector
//  Description : Serialises one-bit automata report wires into {id, timestamp}
//                records, buffers them in a FIFO and presents them on a
//                valid/ready port. The upstream stage cannot be stalled, so a
//                vector that arrives while the collector is still draining is
//                dropped, counted and flagged.
//  Revision    : 1.0 - initial release
// ============================================================================
module automata_report_collector #(
    parameter int NUM_REPORTS = 52,
    parameter int ID_WIDTH    = 6,
    parameter int TS_WIDTH    = 32,
    parameter int FIFO_DEPTH  = 16,
    parameter int DROP_WIDTH  = 16
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               run,
    input  logic [NUM_REPORTS-1:0]             report_vec,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [ID_WIDTH-1:0]                out_id,
    output logic [TS_WIDTH-1:0]                out_ts,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level,
    output logic                               busy,
    output logic                               overflow,
    output logic [DROP_WIDTH-1:0]              drop_count
);

    localparam int c_LVL_W  = $clog2(FIFO_DEPTH + 1);
    localparam int c_ADDR_W = $clog2(FIFO_DEPTH);
    localparam int c_REC_W  = ID_WIDTH + TS_WIDTH;

    localparam logic [0:0] c_ST_IDLE  = 1'b0;
    localparam logic [0:0] c_ST_DRAIN = 1'b1;

    localparam logic [NUM_REPORTS-1:0] c_ONE_VEC  = NUM_REPORTS'(1);
    localparam logic [c_LVL_W-1:0]     c_DEPTH    = c_LVL_W'(FIFO_DEPTH);
    localparam logic [DROP_WIDTH-1:0]  c_DROP_MAX = {DROP_WIDTH{1'b1}};

    // Control state
    logic [0:0]             r_state;
    logic [0:0]             w_state_nxt;
    logic [NUM_REPORTS-1:0] r_pending;
    logic [NUM_REPORTS-1:0] w_pending_nxt;
    logic [TS_WIDTH-1:0]    r_ts_count;
    logic [TS_WIDTH-1:0]    r_ts_latched;
    logic [TS_WIDTH-1:0]    w_ts_latched_nxt;
    logic                   r_overflow;
    logic [DROP_WIDTH-1:0]  r_drop_count;

    // FIFO storage
    logic [c_REC_W-1:0]     r_mem [FIFO_DEPTH];
    logic [c_ADDR_W-1:0]    r_wr_ptr;
    logic [c_ADDR_W-1:0]    r_rd_ptr;
    logic [c_LVL_W-1:0]     r_count;

    // Datapath helpers
    logic                   w_sample;
    logic                   w_has_room;
    logic [NUM_REPORTS-1:0] w_rest;
    logic [ID_WIDTH-1:0]    w_low_idx;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_drop;
    logic [c_REC_W-1:0]     w_head;

    assign w_sample   = run & (|report_vec);
    assign w_has_room = (r_count < c_DEPTH);
    // Clearing the lowest set bit: p & (p - 1)
    assign w_rest     = r_pending & (r_pending - c_ONE_VEC);
    assign w_pop      = (r_count != '0) & out_ready;

    // Priority encoder: index of the lowest set pending bit
    always_comb begin
        w_low_idx = '0;
        for (int i = NUM_REPORTS - 1; i >= 0; i--) begin
            if (r_pending[i]) begin
                w_low_idx = ID_WIDTH'(i);
            end
        end
    end

    // Next-state, pending-vector, push and drop decisions
    always_comb begin
        w_state_nxt      = r_state;
        w_pending_nxt    = r_pending;
        w_ts_latched_nxt = r_ts_latched;
        w_push           = 1'b0;
        w_drop           = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (w_sample) begin
                    w_state_nxt      = c_ST_DRAIN;
                    w_pending_nxt    = report_vec;
                    w_ts_latched_nxt = r_ts_count;
                end
            end
            c_ST_DRAIN: begin
                if (w_has_room) begin
                    w_push        = 1'b1;
                    w_pending_nxt = w_rest;
                end
                if (w_has_room && (w_rest == '0)) begin
                    // Last bit leaves this cycle: a new vector can follow directly
                    if (w_sample) begin
                        w_pending_nxt    = report_vec;
                        w_ts_latched_nxt = r_ts_count;
                    end else begin
                        w_state_nxt = c_ST_IDLE;
                    end
                end else if (w_sample) begin
                    w_drop = 1'b1;
                end
            end
            default: begin
                w_state_nxt   = c_ST_IDLE;
                w_pending_nxt = '0;
            end
        endcase
    end

    // State, pending vector, timestamps and drop bookkeeping
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= c_ST_IDLE;
            r_pending    <= '0;
            r_ts_count   <= '0;
            r_ts_latched <= '0;
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_pending    <= w_pending_nxt;
            r_ts_latched <= w_ts_latched_nxt;
            if (run) begin
                r_ts_count <= r_ts_count + TS_WIDTH'(1);
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_count != c_DROP_MAX) begin
                    r_drop_count <= r_drop_count + DROP_WIDTH'(1);
                end
            end
        end
    end

    // FIFO record storage; contents are meaningless until counted in
    always_ff @(posedge clk) begin
        if (reset && w_push) begin
            r_mem[r_wr_ptr] <= {w_low_idx, r_ts_latched};
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ADDR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ADDR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_LVL_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - c_LVL_W'(1);
            end
        end
    end

    // Head record is forced to zero while the FIFO is empty
    assign w_head     = r_mem[r_rd_ptr];
    assign out_valid  = (r_count != '0);
    assign out_id     = out_valid ? w_head[c_REC_W-1:TS_WIDTH] : '0;
    assign out_ts     = out_valid ? w_head[TS_WIDTH-1:0] : '0;
    assign fifo_level = r_count;
    assign busy       = (r_state == c_ST_DRAIN);
    assign overflow   = r_overflow;
    assign drop_count = r_drop_count;

endmodule
`default_nettype wire

// File: tb/tb_automata_report_collector.sv
`default_nettype none
// ============================================================================
//  Module      : tb_automata_report_collector
//  Description : Directed, table-driven bench for automata_report_collector.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_automata_report_collector;

    localparam int NR = 52;

    typedef struct {
        logic          run;
        logic [NR-1:0] vec;
        logic          rdy;
        logic          e_valid;
        logic [5:0]    e_id;
        logic [31:0]   e_ts;
        logic [4:0]    e_level;
        logic          e_busy;
    } vec_t;

    logic          clk;
    logic          reset;
    logic          run;
    logic [NR-1:0] report_vec;
    logic          out_valid;
    logic          out_ready;
    logic [5:0]    out_id;
    logic [31:0]   out_ts;
    logic [4:0]    fifo_level;
    logic          busy;
    logic          overflow;
    logic [15:0]   drop_count;

    int checks   = 0;
    int failures = 0;

    automata_report_collector dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .report_vec (report_vec),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_id     (out_id),
        .out_ts     (out_ts),
        .fifo_level (fifo_level),
        .busy       (busy),
        .overflow   (overflow),
        .drop_count (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset      = 1'b0;
        run        = 1'b0;
        report_vec = '0;
        out_ready  = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    function automatic vec_t mk(logic r, logic [NR-1:0] v, logic rd, logic ev,
                                int eid, int ets, int elvl, logic eb);
        vec_t t;
        t.run     = r;
        t.vec     = v;
        t.rdy     = rd;
        t.e_valid = ev;
        t.e_id    = 6'(eid);
        t.e_ts    = 32'(ets);
        t.e_level = 5'(elvl);
        t.e_busy  = eb;
        return t;
    endfunction

    vec_t tbl [14];

    initial begin
        logic [NR-1:0] ord_vec;
        int            idx;
        int            cyc;
        int            exp_id [3];
        int            exp_ts [3];

        ord_vec = (52'd1 << 40) | (52'd1 << 3) | (52'd1 << 17);

        // Single report at ts 0, then six idle run cycles, then ordering at ts 7
        tbl[0]  = mk(1, 52'd1 << 5, 0, 0,  0, 0, 0, 1);
        tbl[1]  = mk(0, '0,         0, 1,  5, 0, 1, 0);
        tbl[2]  = mk(0, '0,         1, 0,  0, 0, 0, 0);
        tbl[3]  = mk(1, '0,         1, 0,  0, 0, 0, 0);
        tbl[4]  = mk(1, '0,         1, 0,  0, 0, 0, 0);
        tbl[5]  = mk(1, '0,         1, 0,  0, 0, 0, 0);
        tbl[6]  = mk(1, '0,         1, 0,  0, 0, 0, 0);
        tbl[7]  = mk(1, '0,         1, 0,  0, 0, 0, 0);
        tbl[8]  = mk(1, '0,         1, 0,  0, 0, 0, 0);
        tbl[9]  = mk(1, ord_vec,    1, 0,  0, 0, 0, 1);
        tbl[10] = mk(0, '0,         1, 1,  3, 7, 1, 1);
        tbl[11] = mk(0, '0,         1, 1, 17, 7, 1, 1);
        tbl[12] = mk(0, '0,         1, 1, 40, 7, 1, 0);
        tbl[13] = mk(0, '0,         1, 0,  0, 0, 0, 0);

        // Reset state
        do_reset();
        check("rst_valid",  64'(out_valid),  64'd0);
        check("rst_id",     64'(out_id),     64'd0);
        check("rst_ts",     64'(out_ts),     64'd0);
        check("rst_level",  64'(fifo_level), 64'd0);
        check("rst_busy",   64'(busy),       64'd0);
        check("rst_ovf",    64'(overflow),   64'd0);
        check("rst_drops",  64'(drop_count), 64'd0);

        // Table-driven single-report and ordering
        for (int i = 0; i < 14; i++) begin
            run        = tbl[i].run;
            report_vec = tbl[i].vec;
            out_ready  = tbl[i].rdy;
            tick();
            check($sformatf("tbl%0d_valid", i), 64'(out_valid),  64'(tbl[i].e_valid));
            check($sformatf("tbl%0d_level", i), 64'(fifo_level), 64'(tbl[i].e_level));
            check($sformatf("tbl%0d_busy", i),  64'(busy),       64'(tbl[i].e_busy));
            if (tbl[i].e_valid) begin
                check($sformatf("tbl%0d_id", i), 64'(out_id), 64'(tbl[i].e_id));
                check($sformatf("tbl%0d_ts", i), 64'(out_ts), 64'(tbl[i].e_ts));
            end
        end
        run = 1'b0; report_vec = '0;

        // Back-pressure: 20 bits with ready low, drop while stalled
        do_reset();
        run = 1'b1; report_vec = 52'hFFFFF; tick();
        run = 1'b0; report_vec = '0;
        repeat (16) tick();
        check("bp_level_full", 64'(fifo_level), 64'd16);
        check("bp_busy_stall", 64'(busy),       64'd1);
        check("bp_ovf_before", 64'(overflow),   64'd0);
        check("bp_head_id",    64'(out_id),     64'd0);
        run = 1'b1; report_vec = 52'h1000; tick();
        run = 1'b0; report_vec = '0;
        check("bp_ovf",        64'(overflow),   64'd1);
        check("bp_drops",      64'(drop_count), 64'd1);
        check("bp_level_hold", 64'(fifo_level), 64'd16);
        check("bp_head_hold",  64'(out_id),     64'd0);
        out_ready = 1'b1;
        idx = 0;
        cyc = 0;
        while (idx < 20 && cyc < 100) begin
            if (out_valid) begin
                check($sformatf("bp_id%0d", idx), 64'(out_id), 64'(idx));
                check($sformatf("bp_ts%0d", idx), 64'(out_ts), 64'd0);
                idx++;
            end
            tick();
            cyc++;
        end
        check("bp_records", 64'(idx),        64'd20);
        check("bp_level_0", 64'(fifo_level), 64'd0);
        check("bp_busy_0",  64'(busy),       64'd0);
        check("bp_drops_1", 64'(drop_count), 64'd1);

        // Back-to-back: new vector lands on the cycle the last bit clears
        do_reset();
        run = 1'b1; report_vec = 52'h6;       tick();
        run = 1'b0; report_vec = '0;          tick();
        run = 1'b1; report_vec = 52'd1 << 9;  tick();
        check("b2b_busy_mid", 64'(busy),       64'd1);
        check("b2b_drop_mid", 64'(drop_count), 64'd0);
        run = 1'b0; report_vec = '0;          tick();
        check("b2b_level", 64'(fifo_level), 64'd3);
        check("b2b_busy",  64'(busy),       64'd0);
        check("b2b_drops", 64'(drop_count), 64'd0);
        check("b2b_ovf",   64'(overflow),   64'd0);
        exp_id = '{1, 2, 9};
        exp_ts = '{0, 0, 1};
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("b2b_valid%0d", k), 64'(out_valid), 64'd1);
            check($sformatf("b2b_id%0d", k),    64'(out_id),    64'(exp_id[k]));
            check($sformatf("b2b_ts%0d", k),    64'(out_ts),    64'(exp_ts[k]));
            tick();
        end
        check("b2b_empty", 64'(out_valid), 64'd0);

        // Timestamp gaps: run 1,0,0,1 with reports ignored while run=0
        do_reset();
        out_ready = 1'b0;
        run = 1'b1; report_vec = '0;          tick();
        run = 1'b0; report_vec = 52'hFF;      tick();
        check("gap_busy1", 64'(busy), 64'd0);
        tick();
        check("gap_busy2", 64'(busy), 64'd0);
        run = 1'b1; report_vec = 52'd1 << 7;  tick();
        run = 1'b0; report_vec = '0;          tick();
        check("gap_valid", 64'(out_valid),  64'd1);
        check("gap_id",    64'(out_id),     64'd7);
        check("gap_ts",    64'(out_ts),     64'd1);
        check("gap_level", 64'(fifo_level), 64'd1);

        // Reset mid-drain with five records buffered and a drop recorded
        do_reset();
        out_ready = 1'b0;
        run = 1'b1; report_vec = '0;    tick();
        tick();
        report_vec = 52'hFF;            tick();
        report_vec = 52'h1;             tick();
        run = 1'b0; report_vec = '0;
        repeat (4) tick();
        check("mid_level", 64'(fifo_level), 64'd5);
        check("mid_busy",  64'(busy),       64'd1);
        check("mid_ovf",   64'(overflow),   64'd1);
        reset = 1'b0; tick();
        check("mrst_level", 64'(fifo_level), 64'd0);
        check("mrst_valid", 64'(out_valid),  64'd0);
        check("mrst_busy",  64'(busy),       64'd0);
        check("mrst_ovf",   64'(overflow),   64'd0);
        check("mrst_drops", 64'(drop_count), 64'd0);
        check("mrst_id",    64'(out_id),     64'd0);
        reset = 1'b1;
        run = 1'b1; report_vec = 52'd1 << 2;  tick();
        run = 1'b0; report_vec = '0;          tick();
        check("post_valid", 64'(out_valid),  64'd1);
        check("post_id",    64'(out_id),     64'd2);
        check("post_ts",    64'(out_ts),     64'd0);
        check("post_level", 64'(fifo_level), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
